// File: rtl/q_window_avg.sv
// Q measurement conditioner: drops a settling run after every i_ref change or reset,
// then emits floor-averaged windows of 2**LOG2_N valid samples with a one-cycle ready strobe.
module q_window_avg #(
    parameter int WIDTH  = 10,
    parameter int LOG2_N = 3,
    parameter int SETTLE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_ref,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample_q,
    output logic [WIDTH-1:0] measured_q,
    output logic             ready,
    output logic             settling
);

    localparam int ACC_W  = WIDTH + LOG2_N;
    localparam int SCNT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE);

    localparam logic [SCNT_W-1:0] SETTLE_LAST = SCNT_W'((SETTLE == 0) ? 0 : SETTLE - 1);
    localparam logic [LOG2_N-1:0] WIN_LAST    = '1;

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_ACCUM  = 1'b1
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   i_ref_q;
    logic [SCNT_W-1:0]  settle_cnt_q;
    logic [LOG2_N-1:0]  win_cnt_q;
    logic [ACC_W-1:0]   acc_q;
    logic [WIDTH-1:0]   meas_q;
    logic               ready_q;
    logic               settling_q;

    logic               chg;
    logic [ACC_W-1:0]   sum_d;

    // The window total including the current sample; it fits ACC_W bits by construction.
    assign chg   = (i_ref != i_ref_q);
    assign sum_d = acc_q + ACC_W'(sample_q);

    always_ff @(posedge clk) begin
        i_ref_q <= i_ref;
        ready_q <= 1'b0;
        if (!rst) begin
            state_q      <= ST_SETTLE;
            settle_cnt_q <= '0;
            win_cnt_q    <= '0;
            acc_q        <= '0;
            meas_q       <= '0;
            settling_q   <= 1'b1;
        end else if (chg) begin
            // The sample on the change edge belongs to neither the old nor the new operating point.
            state_q      <= ST_SETTLE;
            settle_cnt_q <= '0;
            win_cnt_q    <= '0;
            acc_q        <= '0;
            settling_q   <= 1'b1;
        end else begin
            case (state_q)
                ST_SETTLE: begin
                    if (SETTLE == 0) begin
                        state_q    <= ST_ACCUM;
                        win_cnt_q  <= '0;
                        acc_q      <= '0;
                        settling_q <= 1'b0;
                    end else if (sample_valid) begin
                        if (settle_cnt_q == SETTLE_LAST) begin
                            state_q      <= ST_ACCUM;
                            settle_cnt_q <= '0;
                            win_cnt_q    <= '0;
                            acc_q        <= '0;
                            settling_q   <= 1'b0;
                        end else begin
                            settle_cnt_q <= settle_cnt_q + 1'b1;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (sample_valid) begin
                        if (win_cnt_q == WIN_LAST) begin
                            meas_q    <= WIDTH'(sum_d >> LOG2_N);
                            ready_q   <= 1'b1;
                            acc_q     <= '0;
                            win_cnt_q <= '0;
                        end else begin
                            acc_q     <= sum_d;
                            win_cnt_q <= win_cnt_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign measured_q = meas_q;
    assign ready      = ready_q;
    assign settling   = settling_q;

endmodule

// File: tb/tb_q_window_avg.sv
// Directed bench for q_window_avg: stimulus pushes expected averages and strobe cycles,
// a negedge monitor pops and compares them whenever ready is seen.
module tb_q_window_avg;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] iRef;
    logic       sampleValid;
    logic [9:0] sampleQ;
    logic [9:0] measuredQ;
    logic       ready;
    logic       settling;

    logic       rst0;
    logic [9:0] iRef0;
    logic       sv0;
    logic [9:0] sq0;
    logic [9:0] measured0;
    logic       ready0;
    logic       settling0;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int value;
        int cycle;
    } expT;

    expT expQ[$];

    q_window_avg #(.WIDTH(10), .LOG2_N(3), .SETTLE(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_ref        (iRef),
        .sample_valid (sampleValid),
        .sample_q     (sampleQ),
        .measured_q   (measuredQ),
        .ready        (ready),
        .settling     (settling)
    );

    q_window_avg #(.WIDTH(10), .LOG2_N(3), .SETTLE(0)) dut0 (
        .clk          (clk),
        .rst          (rst0),
        .i_ref        (iRef0),
        .sample_valid (sv0),
        .sample_q     (sq0),
        .measured_q   (measured0),
        .ready        (ready0),
        .settling     (settling0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, required %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Inputs change on the falling edge so the next rising edge samples them cleanly.
    task automatic applyStimulus(input logic r, input logic v, input logic [9:0] q, input logic [9:0] ir);
        @(negedge clk);
        rst         = r;
        sampleValid = v;
        sampleQ     = q;
        iRef        = ir;
    endtask

    task automatic expectReady(input int value);
        expT e;
        e.value = value;
        e.cycle = cyc + 1;
        expQ.push_back(e);
    endtask

    always @(negedge clk) begin
        if (ready === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_ready: got strobe with measured_q=%0d at cycle %0d, required none", measuredQ, cyc);
            end else begin
                expT e;
                e = expQ.pop_front();
                checkOutput("ready_value", int'(measuredQ), e.value);
                checkOutput("ready_cycle", cyc, e.cycle);
            end
        end
    end

    initial begin
        rst = 1'b0; sampleValid = 1'b0; sampleQ = '0; iRef = 10'd512;
        rst0 = 1'b0; sv0 = 1'b0; sq0 = '0; iRef0 = 10'd512;

        applyStimulus(1'b0, 1'b0, 10'd0, 10'd512);
        applyStimulus(1'b0, 1'b0, 10'd0, 10'd512);
        checkOutput("reset_measured_q", int'(measuredQ), 0);
        checkOutput("reset_ready", int'(ready), 0);
        checkOutput("reset_settling", int'(settling), 1);

        // Steady state: 4 settle + 8 window samples, then one strobe per 8 samples.
        for (int i = 1; i <= 12; i++) begin
            applyStimulus(1'b1, 1'b1, 10'd100, 10'd512);
            checkOutput("s1_settling", int'(settling), (i <= 4) ? 1 : 0);
            if (i == 12) expectReady(100);
        end
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 1'b1, 10'd100, 10'd512);
            if (i == 8) expectReady(100);
        end

        // Truncation (36/8 -> 4) and full scale without wrap.
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 1'b1, 10'(i), 10'd512);
            if (i == 8) expectReady(4);
        end
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 1'b1, 10'd1023, 10'd512);
            if (i == 8) expectReady(1023);
        end
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 1'b1, 10'd100, 10'd512);
            if (i == 8) expectReady(100);
        end

        // Mid-window change after 5 accumulated samples.
        for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 1'b1, 10'd100, 10'd512);
        applyStimulus(1'b1, 1'b1, 10'd200, 10'd600);
        for (int j = 1; j <= 12; j++) begin
            applyStimulus(1'b1, 1'b1, 10'd200, 10'd600);
            if (j == 1) begin
                checkOutput("s3_settling", int'(settling), 1);
                checkOutput("s3_hold_first", int'(measuredQ), 100);
            end
            if (j == 12) begin
                checkOutput("s3_hold_last", int'(measuredQ), 100);
                expectReady(200);
            end
        end

        // Change on the edge that would have completed the window.
        for (int i = 1; i <= 7; i++) applyStimulus(1'b1, 1'b1, 10'd50, 10'd600);
        applyStimulus(1'b1, 1'b1, 10'd50, 10'd512);
        for (int j = 1; j <= 12; j++) begin
            applyStimulus(1'b1, 1'b1, 10'd300, 10'd512);
            if (j == 1) begin
                checkOutput("s4_settling", int'(settling), 1);
                checkOutput("s4_hold", int'(measuredQ), 200);
            end
            if (j == 12) expectReady(300);
        end

        // Gapped input; invalid cycles carry 1023 garbage, window is 10..80 -> 45.
        applyStimulus(1'b1, 1'b0, 10'd1023, 10'd700);
        for (int k = 0; k < 24; k++) begin
            if (k % 2 == 0) begin
                int j;
                j = k / 2;
                applyStimulus(1'b1, 1'b1, (j < 4) ? 10'd999 : 10'((j - 3) * 10), 10'd700);
                if (k == 22) expectReady(45);
            end else begin
                applyStimulus(1'b1, 1'b0, 10'd1023, 10'd700);
            end
        end

        // Reset mid-window, then full recovery.
        for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 1'b1, 10'd100, 10'd700);
        applyStimulus(1'b0, 1'b1, 10'd100, 10'd700);
        for (int j = 1; j <= 12; j++) begin
            applyStimulus(1'b1, 1'b1, 10'd100, 10'd700);
            if (j == 1) begin
                checkOutput("s6_measured_q", int'(measuredQ), 0);
                checkOutput("s6_ready", int'(ready), 0);
                checkOutput("s6_settling", int'(settling), 1);
            end
            if (j == 12) expectReady(100);
        end

        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 10'd0, 10'd700);
        checkOutput("scoreboard_empty", expQ.size(), 0);

        // SETTLE=0 build: the release edge consumes nothing, the next 8 samples form the window.
        checkOutput("s0_reset_settling", int'(settling0), 1);
        @(negedge clk);
        rst0 = 1'b1; sv0 = 1'b1; sq0 = 10'd1023;
        @(negedge clk);
        checkOutput("s0_settling", int'(settling0), 0);
        sq0 = 10'd77;
        for (int k = 2; k <= 9; k++) begin
            @(negedge clk);
            checkOutput("s0_ready", int'(ready0), (k == 9) ? 1 : 0);
            if (k == 9) checkOutput("s0_measured", int'(measured0), 77);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/q_window_avg.md
# q_window_avg

Upstream measurement stage of the Q control loop. Conditions raw Q samples into the `measured_q` / `ready` pair consumed by the bisection and secant current controllers. After every change of `i_ref` it discards a settling run of samples, then averages a power-of-two window of valid samples. It presents each average with a one-cycle `ready` strobe, so the controller only iterates on settled, de-noised measurements.

## Interface

Parameters:
- `WIDTH`, 10, bit width of `i_ref`, `sample_q` and `measured_q`.
- `LOG2_N`, 3, log2 of the averaging window size; N = 2**LOG2_N valid samples per result.
- `SETTLE`, 4, number of valid samples discarded after reset or an `i_ref` change. 0 is legal.

Ports:
- `clk`  in  1  single clock; everything updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `i_ref`  in  WIDTH  current reference currently driven by the controller.
- `sample_valid`  in  1  `sample_q` is valid this cycle.
- `sample_q`  in  WIDTH  raw Q sample, unsigned.
- `measured_q`  out  WIDTH  latest window average, unsigned.
- `ready`  out  1  one-cycle strobe: `measured_q` has just been updated.
- `settling`  out  1  high while in SETTLE; samples are being discarded.

## Operation

- **Change detect:** `i_ref_q` registers `i_ref` every cycle. `chg = (i_ref != i_ref_q)` is combinational.
- **States:**
  - SETTLE: discard valid samples.
  - ACCUM: sum valid samples.
  - There is no idle state; averaging runs continuously.
- **Reset** (`rst`==0 at an edge):
  - state goes to SETTLE; `settle_cnt` = 0, `win_cnt` = 0, `acc` = 0.
  - `i_ref_q` loads `i_ref`, so there is no spurious change on release.
  - `measured_q` = 0, `ready` = 0, `settling` = 1.
- **Priority per edge:** reset > `chg` > sample handling.
- **`chg`=1 in any state:**
  - go to SETTLE and clear `settle_cnt`, `win_cnt` and `acc`.
  - any sample in that cycle is dropped and does not count toward SETTLE.
  - no `ready` is issued, even if the sample would have completed a window.
  - `measured_q` holds its previous value.
- **SETTLE:**
  - each valid sample increments `settle_cnt`.
  - on the SETTLE-th valid sample, go to ACCUM with `win_cnt` = 0 and `acc` = 0.
  - with SETTLE = 0, the state is left on the edge after entry regardless of `sample_valid`, and no sample is consumed.
- **ACCUM:**
  - each valid sample does `acc += sample_q` and `win_cnt += 1`.
  - `acc` is WIDTH+LOG2_N bits wide and can never overflow.
  - on the N-th sample:
    - `measured_q <= (acc + sample_q) >> LOG2_N`, truncating (floor).
    - `ready <= 1`.
    - `acc` and `win_cnt` clear, and the state stays in ACCUM for the next window.
- **Outputs:**
  - `ready` is 0 on every edge except the window-complete edge.
  - `measured_q` changes only on that edge or on reset.
- `settling` = (state == SETTLE), registered.
- `sample_valid`=0 cycles are ignored; the counters hold.

## Timing

- All outputs are registered; there is no combinational input-to-output path.
- **Latency to `ready`:** `ready` goes high in the cycle following the edge that accepts the last window sample, and stays high for exactly one cycle.
- **Edge E** is the edge at which `chg` (or reset release) is seen. With `sample_valid` held high from E onward:
  - the first `ready` goes high after edge E + SETTLE + N.
  - subsequent `ready` strobes occur every N cycles.
- **Gapped input:** latency counts valid samples only.
- **Controller handshake:** the controller may change `i_ref` in the cycle `ready` is high. That change is detected at the next edge, which restarts settling.
- **Reset mid-window:** the partial sum is lost. `measured_q` returns to 0.

## Test plan

All scenarios use WIDTH=10, LOG2_N=3, SETTLE=4.

1. **Steady state:** `rst` low 2 cycles, then high; `i_ref`=512 constant; `sample_q`=100 valid every cycle -> first `ready` after the 12th post-reset edge with `measured_q`=100; then `ready` every 8 cycles; `settling` high for exactly the first 4 cycles.
2. **Truncation:** after settling, window samples 1,2,...,8 (sum 36) -> `measured_q`=4. Full scale, 8×1023 -> `measured_q`=1023 with no wrap.
3. **Mid-window change:** `i_ref` 512→600 after 5 ACCUM samples (old value 100, new value 200) -> no `ready`; `settling` re-asserts; next `ready` after 12 further valid samples with `measured_q`=200; `measured_q` holds 100 until then.
4. **Change coinciding with final sample:** `i_ref` change on the same edge as the 8th window sample -> no `ready`; that sample is not counted; the 12-sample restart is verified.
5. **Gapped input:** `sample_valid` toggles 1,0,1,0 -> first `ready` after 24 cycles; the average is correct with the invalid-cycle `sample_q`=1023 garbage excluded.
6. **Reset mid-ACCUM:** `rst` low for 1 cycle mid-window -> next cycle `measured_q`=0, `ready`=0, `settling`=1; recovery as in scenario 1. A SETTLE=0 build reaches its first `ready` 1+8 cycles after reset release.
